// File: rtl/seq_detector_prog.sv
// Serial MSB-first pattern detector with runtime-loadable pattern, optional
// overlapping detection and a saturating match counter. Output is registered.
module seq_detector_prog #(
  parameter int unsigned           PAT_W   = 4,
  parameter int unsigned           CNT_W   = 8,
  parameter logic [PAT_W-1:0]      RST_PAT = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             overlap,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pat_q
);

  localparam int unsigned FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d, hist_n;
  logic [FW-1:0]    fill_q, fill_d, fill_n;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] pat_d;
  logic             det;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    out_d  = 1'b0;
    cnt_d  = cnt_q;
    det    = 1'b0;
    hist_n = {hist_q[PAT_W-2:0], in};
    fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);

    if (load) begin
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      // fill guard keeps the zeroed history from matching an all-zero pattern
      det    = (fill_n == FILL_FULL) && (hist_n == pat_q);
      hist_d = hist_n;
      out_d  = det;
      fill_d = (det && !overlap) ? '0 : fill_n;
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (det && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
      pat_q  <= RST_PAT;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench: a queue-of-bits reference model predicts each cycle's outputs
// for two detector instances (8-bit and 2-bit counters) sharing one input stream.
module tb_seq_detector_prog;

  localparam int unsigned PAT_W = 4;
  localparam logic [3:0]  RST_P = 4'b1011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in = 1'b0;
  logic       en = 1'b0;
  logic       overlap = 1'b1;
  logic       load = 1'b0;
  logic [3:0] pattern = '0;
  logic       clr_cnt = 1'b0;

  logic       out_a, out_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [3:0] pat_a, pat_b;

  always #5 clk = ~clk;

  seq_detector_prog #(.PAT_W(4), .CNT_W(8), .RST_PAT(RST_P)) dut_a (
    .clk(clk), .rst(rst), .in(in), .en(en), .overlap(overlap), .load(load),
    .pattern(pattern), .clr_cnt(clr_cnt), .out(out_a), .match_cnt(cnt_a), .pat_q(pat_a)
  );

  seq_detector_prog #(.PAT_W(4), .CNT_W(2), .RST_PAT(RST_P)) dut_b (
    .clk(clk), .rst(rst), .in(in), .en(en), .overlap(overlap), .load(load),
    .pattern(pattern), .clr_cnt(clr_cnt), .out(out_b), .match_cnt(cnt_b), .pat_q(pat_b)
  );

  typedef struct packed {
    logic       out;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [3:0] pat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: bits seen since the last reset/load/non-overlap detect.
  bit         seen[$];
  int         m_cnt8 = 0;
  int         m_cnt2 = 0;
  logic [3:0] m_pat = RST_P;

  task automatic step(input logic r, input logic ld, input logic [3:0] pt,
                      input logic e, input logic b, input logic ov, input logic clr);
    exp_t x;
    bit   det;
    rst = r; load = ld; pattern = pt; en = e; in = b; overlap = ov; clr_cnt = clr;
    det = 1'b0;
    if (!r) begin
      seen.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
      m_pat  = RST_P;
    end else begin
      if (ld) begin
        m_pat = pt;
        seen.delete();
      end else if (e) begin
        seen.push_back(b);
        if (seen.size() > PAT_W) void'(seen.pop_front());
        if (seen.size() == PAT_W) begin
          det = 1'b1;
          for (int i = 0; i < PAT_W; i++)
            if (seen[i] != m_pat[PAT_W-1-i]) det = 1'b0;
        end
        if (det && !ov) seen.delete();
      end
      if (clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (det) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
    x.out  = det;
    x.cnt8 = 8'(m_cnt8);
    x.cnt2 = 2'(m_cnt2);
    x.pat  = m_pat;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic bit_in(input logic b, input logic ov);
    step(1'b1, 1'b0, 4'h0, 1'b1, b, ov, 1'b0);
  endtask

  task automatic bits(input logic [15:0] v, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) bit_in(v[i], ov);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_load(input logic [3:0] p);
    step(1'b1, 1'b1, p, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // Monitor: compares every registered output one time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (out_a !== e.out) begin
          errors++;
          $display("FAIL out_a t=%0t got=%b exp=%b", $time, out_a, e.out);
        end
        checks++;
        if (out_b !== e.out) begin
          errors++;
          $display("FAIL out_b t=%0t got=%b exp=%b", $time, out_b, e.out);
        end
        checks++;
        if (cnt_a !== e.cnt8) begin
          errors++;
          $display("FAIL cnt8 t=%0t got=%0d exp=%0d", $time, cnt_a, e.cnt8);
        end
        checks++;
        if (cnt_b !== e.cnt2) begin
          errors++;
          $display("FAIL cnt2 t=%0t got=%0d exp=%0d", $time, cnt_b, e.cnt2);
        end
        checks++;
        if (pat_a !== e.pat || pat_b !== e.pat) begin
          errors++;
          $display("FAIL pat t=%0t got=%h/%h exp=%h", $time, pat_a, pat_b, e.pat);
        end
      end
    end
  end

  initial begin
    int budget;
    #2;
    // 1) overlapping 1011 on 1,0,1,1,0,1,1
    do_reset();
    bits(16'b1011011, 7, 1'b1);
    // 2) same stream, non-overlapping
    do_reset();
    bits(16'b1011011, 7, 1'b0);
    // 3) pattern 1111, overlap then non-overlap
    do_reset();
    do_load(4'b1111);
    bits(16'b111111, 6, 1'b1);
    do_load(4'b1111);
    bits(16'b111111, 6, 1'b0);
    // 4) en gap in the middle of a match
    do_reset();
    bits(16'b101, 3, 1'b1);
    idle(3);
    bit_in(1'b1, 1'b1);
    // 5) saturation of the 2-bit counter, then clr_cnt on a detect edge
    do_reset();
    do_load(4'b1111);
    bits(16'b1111111, 7, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    // 6) reset and load in mid-stream
    do_reset();
    bits(16'b101, 3, 1'b1);
    do_reset();
    bit_in(1'b1, 1'b1);
    bits(16'b101, 3, 1'b1);
    do_load(4'b0110);
    bits(16'b10110, 5, 1'b1);
    // all-zero pattern: zero history after load must not match early
    do_load(4'b0000);
    bits(16'b00000, 5, 1'b1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, clr;
      r   = ($urandom_range(0, 199) != 0);
      ld  = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 49) == 0);
      step(r, ld, 4'($urandom), ($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom), clr);
    end
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
